wrr_arbiter: RTL

Parametrised weighted round-robin arbiter: N requesters share one downstream resource. Each grant lasts up to a programmable number of accepted beats, or until end of packet, before moving on. Fairness is round-robin. This successor to the 3-channel single-cycle round-robin arbiter adds channel-count/weight parametrisation, beat-level handshake with downstream, packet lock and graceful disable. It sits between N request sources and a shared bus/port mux driven by `o_grant`.

---
 rtl/wrr_arbiter_pkg.sv | 21 ++
 rtl/wrr_arbiter_if.sv | 42 ++++
 rtl/wrr_arbiter_rr_pick.sv | 32 +++
 rtl/wrr_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

    localparam int unsigned N_MAX = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index width for n channels, bounded by the largest supported count.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned k = 2; k <= N_MAX; k = k * 2) begin
            if (k < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
// The weight vector exists only when WRR_ARBITER_WEIGHT_EN is defined.
interface wrr_arbiter_if #(
    parameter int unsigned N  = 4
`ifdef WRR_ARBITER_WEIGHT_EN
   ,parameter int unsigned WW = 4
`endif
);
    import wrr_arbiter_pkg::*;

    localparam int unsigned IDX_W = idx_w(N);

    logic             en;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_last;
`ifdef WRR_ARBITER_WEIGHT_EN
    logic [N*WW-1:0]  weight;
`endif
    logic             gnt_rdy;
    logic [N-1:0]     o_grant;
    logic [IDX_W-1:0] o_grant_idx;
    logic             o_grant_vld;

    modport master (
        output en, req_vld, req_last,
`ifdef WRR_ARBITER_WEIGHT_EN
        output weight,
`endif
        output gnt_rdy,
        input  o_grant, o_grant_idx, o_grant_vld
    );

    modport slave (
        input  en, req_vld, req_last,
`ifdef WRR_ARBITER_WEIGHT_EN
        input  weight,
`endif
        input  gnt_rdy,
        output o_grant, o_grant_idx, o_grant_vld
    );

endinterface

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating-priority find-first: first set request at or above i_ptr, wrapping.
module wrr_arbiter_rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_pick,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_ch;

    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_ch   = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_ch = IDX_W'((int'(i_ptr) + i) % int'(N));
            if (!o_any && i_req[w_ch]) begin
                o_pick[w_ch] = 1'b1;
                o_idx        = w_ch;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with beat handshake, packet lock and graceful disable.
// WRR_ARBITER_WEIGHT_EN adds per-channel beat credits; otherwise grants last one packet.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4
`ifdef WRR_ARBITER_WEIGHT_EN
   ,parameter int unsigned WW = 4
`endif
) (
    input  logic         clk,
    input  logic         asrst_n,
    wrr_arbiter_if.slave arb
);

    localparam int unsigned IDX_W = idx_w(N);

    state_e           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_grant;
    logic             r_vld;

    logic [N-1:0]     w_pick;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_pick_ptr;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_any;
    logic             w_cur_vld;
    logic             w_accept;
    logic             w_release;
    logic             w_launch;

    // On release the search starts just past the current owner, so it wins last.
    assign w_next_ptr = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
    assign w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;

    wrr_arbiter_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req  (arb.req_vld),
        .i_ptr  (w_pick_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

    assign w_cur_vld = arb.req_vld[r_idx];
    assign w_accept  = (r_state == GRANT) & w_cur_vld & arb.gnt_rdy;
    assign w_launch  = arb.en & w_any;

`ifdef WRR_ARBITER_WEIGHT_EN
    logic [WW-1:0] r_credit;
    logic [WW-1:0] w_wsel;
    logic [WW-1:0] w_load;

    // Weight zero still earns one beat so a requester can never starve itself.
    assign w_wsel    = arb.weight[int'(w_pick_idx) * WW +: WW];
    assign w_load    = (w_wsel == '0) ? WW'(1) : w_wsel;
    assign w_release = (r_state == GRANT) &
                       (~w_cur_vld | (w_accept & (arb.req_last[r_idx] | (r_credit == WW'(1)))));

    always_ff @(posedge clk or negedge asrst_n) begin
        if (!asrst_n) begin
            r_credit <= '0;
        end else if ((r_state == IDLE || w_release) && w_launch) begin
            r_credit <= w_load;
        end else if (w_accept && !w_release) begin
            r_credit <= r_credit - WW'(1);
        end
    end
`else
    assign w_release = (r_state == GRANT) & (~w_cur_vld | (w_accept & arb.req_last[r_idx]));
`endif

    always_ff @(posedge clk or negedge asrst_n) begin
        if (!asrst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= GRANT;
                        r_grant <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_vld   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_launch) begin
                            r_grant <= w_pick;
                            r_idx   <= w_pick_idx;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_idx   <= '0;
                            r_vld   <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign arb.o_grant     = r_grant;
    assign arb.o_grant_idx = r_idx;
    assign arb.o_grant_vld = r_vld;

endmodule
